// File: rtl/pipe_sched_if.sv
// ---------------------------------------------------------------------------
// pipe_sched_if -- signal bundle between a 5-stage pipeline and its hazard /
// wait-state / debug scheduler.
//
// Pipeline -> scheduler (driven by the master side):
//   i_ld_e       EX-stage instruction is a load
//   i_rd_e       EX-stage destination register
//   i_rs1_d      ID-stage source register 1
//   i_rs2_d      ID-stage source register 2
//   i_pcsrc_e    branch/jump taken, resolved in EX
//   i_mem_req_m  MEM-stage access to a wait-stated resource
//   i_mem_ack    wait-stated resource completed the access
//   i_halt_req   debug halt request (level)
//   i_step       single-step pulse, honoured only while halted
//
// Scheduler -> pipeline (driven by the slave side):
//   o_stall_fd   hold PC and IF/ID
//   o_flush_d    bubble IF/ID
//   o_flush_e    bubble ID/EX
//   o_freeze     hold every pipeline register and PC
//   o_mem_err    one-cycle pulse when a MEM access is abandoned
//   o_state      scheduler state: 00 RUN, 01 MEMWAIT, 10 HALT, 11 STEP
//   o_stall_cnt  saturating count of stalled/frozen cycles
// ---------------------------------------------------------------------------
interface pipe_sched_if;
    logic        i_ld_e;
    logic [4:0]  i_rd_e;
    logic [4:0]  i_rs1_d;
    logic [4:0]  i_rs2_d;
    logic        i_pcsrc_e;
    logic        i_mem_req_m;
    logic        i_mem_ack;
    logic        i_halt_req;
    logic        i_step;

    logic        o_stall_fd;
    logic        o_flush_d;
    logic        o_flush_e;
    logic        o_freeze;
    logic        o_mem_err;
    logic [1:0]  o_state;
    logic [15:0] o_stall_cnt;

    // Pipeline side.
    modport master (
        output i_ld_e, i_rd_e, i_rs1_d, i_rs2_d, i_pcsrc_e,
               i_mem_req_m, i_mem_ack, i_halt_req, i_step,
        input  o_stall_fd, o_flush_d, o_flush_e, o_freeze,
               o_mem_err, o_state, o_stall_cnt
    );

    // Scheduler side.
    modport slave (
        input  i_ld_e, i_rd_e, i_rs1_d, i_rs2_d, i_pcsrc_e,
               i_mem_req_m, i_mem_ack, i_halt_req, i_step,
        output o_stall_fd, o_flush_d, o_flush_e, o_freeze,
               o_mem_err, o_state, o_stall_cnt
    );
endinterface

// File: rtl/pipe_sched.sv
// ---------------------------------------------------------------------------
// pipe_sched -- pipeline scheduler for a 5-stage in-order core.
//
// Resolves load-use and branch hazards, freezes the whole pipeline while a
// wait-stated MEM access is outstanding (abandoning it after MEM_TIMEOUT
// wait cycles), and implements debug halt / single-step.
//
// Ports:
//   i_clk  clock, all state updates on the rising edge
//   i_rst  synchronous active-high reset
//   bus    pipe_sched_if.slave, see the interface file for each signal
//
// Parameter:
//   MEM_TIMEOUT  wait cycles allowed for i_mem_ack before the access is
//                abandoned and o_mem_err pulses (1..255)
// ---------------------------------------------------------------------------
module pipe_sched #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic         i_clk,
    input  logic         i_rst,
    pipe_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        HALT    = 2'b10,
        STEP    = 2'b11
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t      state_q;
    state_t      state_nx;
    state_t      dec_state;
    logic [7:0]  wait_q;
    logic [7:0]  wait_nx;
    logic [15:0] stall_cnt_q;

    logic        load_use;
    logic        mem_stall;
    logic        freeze;
    logic        mem_err;

    // Hazard and wait-state conditions straight from the pipeline.
    assign load_use  = bus.i_ld_e && (bus.i_rd_e != 5'd0) &&
                       ((bus.i_rd_e == bus.i_rs1_d) || (bus.i_rd_e == bus.i_rs2_d));
    assign mem_stall = bus.i_mem_req_m && !bus.i_mem_ack;

    // While reset is held the combinational outputs decode as RUN, so a
    // reset taken mid-MEMWAIT can never raise a late o_mem_err.
    assign dec_state = i_rst ? RUN : state_q;

    // -----------------------------------------------------------------------
    // Next-state / output decode
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx = state_q;
        wait_nx  = wait_q;
        freeze   = 1'b0;
        mem_err  = 1'b0;

        unique case (dec_state)
            RUN: begin
                if (mem_stall) begin
                    freeze   = 1'b1;
                    state_nx = MEMWAIT;
                    wait_nx  = 8'd1;
                end else if (bus.i_halt_req && !bus.i_mem_req_m) begin
                    // A halt is only taken between MEM accesses.
                    state_nx = HALT;
                end else begin
                    state_nx = RUN;
                end
            end

            MEMWAIT: begin
                if (bus.i_mem_ack) begin
                    // Access completes this cycle; pipeline moves again.
                    state_nx = RUN;
                    wait_nx  = 8'd0;
                end else if (wait_q == TIMEOUT) begin
                    // Give up on the resource and let the pipeline proceed.
                    mem_err  = 1'b1;
                    state_nx = RUN;
                    wait_nx  = 8'd0;
                end else begin
                    freeze  = 1'b1;
                    wait_nx = wait_q + 8'd1;
                end
            end

            HALT: begin
                freeze = 1'b1;
                if (!bus.i_halt_req) begin
                    state_nx = RUN;
                    wait_nx  = 8'd0;
                end else if (bus.i_step) begin
                    state_nx = STEP;
                end
            end

            STEP: begin
                // Exactly one cycle of forward progress, then back to HALT
                // unless the debugger released the core meanwhile.
                if (mem_stall) begin
                    freeze   = 1'b1;
                    state_nx = MEMWAIT;
                    wait_nx  = 8'd1;
                end else if (bus.i_halt_req) begin
                    state_nx = HALT;
                end else begin
                    state_nx = RUN;
                    wait_nx  = 8'd0;
                end
            end

            default: begin
                state_nx = RUN;
                wait_nx  = 8'd0;
            end
        endcase
    end

    // Freeze dominates: a frozen pipeline must not also see local stalls or
    // bubbles. A taken branch squashes the load-use consumer, so it wins.
    assign bus.o_freeze   = freeze;
    assign bus.o_mem_err  = mem_err;
    assign bus.o_stall_fd = !freeze && load_use && !bus.i_pcsrc_e;
    assign bus.o_flush_d  = !freeze && bus.i_pcsrc_e;
    assign bus.o_flush_e  = !freeze && (bus.i_pcsrc_e || load_use);

    // -----------------------------------------------------------------------
    // State register and counters
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= RUN;
            wait_q      <= 8'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q <= state_nx;
            wait_q  <= wait_nx;
            if ((bus.o_stall_fd || freeze) && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign bus.o_state     = state_q;
    assign bus.o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_sched.sv
// ---------------------------------------------------------------------------
// tb_pipe_sched -- self-checking bench for pipe_sched (MEM_TIMEOUT = 4).
// A table of single-cycle hazard vectors, hand-written multi-cycle
// sequences and a randomized run, all compared against a reference model.
// ---------------------------------------------------------------------------
module tb_pipe_sched;

    localparam int TMO = 4;

    logic i_clk = 1'b0;
    logic i_rst;

    pipe_sched_if bus ();

    pipe_sched #(.MEM_TIMEOUT(TMO)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       pcsrc;
        logic       req;
        logic       ack;
        logic       halt;
        logic       step;
    } in_t;

    typedef struct {
        in_t  in;
        logic stall_fd;
        logic flush_d;
        logic flush_e;
        logic freeze;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the scheduler is doing, described as facts
    // about the pipeline rather than as an encoded state.
    bit m_pending;    // a MEM access is being waited on
    int m_waited;     // wait cycles spent on it so far
    bit m_halted;     // debugger holds the core
    bit m_stepping;   // this cycle is the single released step
    int m_cnt;        // stalled/frozen cycle count

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t v;
        v.rst = 1'b0; v.ld = 1'b0; v.rd = 5'd0; v.rs1 = 5'd0; v.rs2 = 5'd0;
        v.pcsrc = 1'b0; v.req = 1'b0; v.ack = 1'b0; v.halt = 1'b0; v.step = 1'b0;
        return v;
    endfunction

    task automatic apply(input in_t v);
        i_rst           = v.rst;
        bus.i_ld_e      = v.ld;
        bus.i_rd_e      = v.rd;
        bus.i_rs1_d     = v.rs1;
        bus.i_rs2_d     = v.rs2;
        bus.i_pcsrc_e   = v.pcsrc;
        bus.i_mem_req_m = v.req;
        bus.i_mem_ack   = v.ack;
        bus.i_halt_req  = v.halt;
        bus.i_step      = v.step;
    endtask

    task automatic model_reset();
        m_pending = 0; m_waited = 0; m_halted = 0; m_stepping = 0; m_cnt = 0;
    endtask

    // Compare all outputs with the model for the inputs currently applied,
    // advance the model, and move to just after the next rising edge.
    task automatic step_cycle();
        bit lu, stall_m, fr, er, sfd, fd, fe;
        int st;
        #2;
        lu = bus.i_ld_e && (bus.i_rd_e != 0) &&
             (bus.i_rd_e == bus.i_rs1_d || bus.i_rd_e == bus.i_rs2_d);
        stall_m = bus.i_mem_req_m && !bus.i_mem_ack;
        fr = 0;
        er = 0;
        st = m_pending ? 1 : (m_halted ? (m_stepping ? 3 : 2) : 0);

        if (i_rst) begin
            fr = stall_m;
        end else if (m_pending) begin
            if (bus.i_mem_ack) begin
                m_pending = 0; m_waited = 0;
            end else if (m_waited == TMO) begin
                er = 1; m_pending = 0; m_waited = 0;
            end else begin
                fr = 1; m_waited++;
            end
        end else if (m_halted && !m_stepping) begin
            fr = 1;
            if (!bus.i_halt_req) m_halted = 0;
            else if (bus.i_step) m_stepping = 1;
        end else if (stall_m) begin
            fr = 1; m_pending = 1; m_waited = 1; m_halted = 0; m_stepping = 0;
        end else if (m_stepping) begin
            m_stepping = 0; m_halted = bus.i_halt_req;
        end else begin
            m_halted = bus.i_halt_req && !bus.i_mem_req_m;
        end

        sfd = !fr && lu && !bus.i_pcsrc_e;
        fd  = !fr && bus.i_pcsrc_e;
        fe  = !fr && (bus.i_pcsrc_e || lu);

        check("freeze",    bus.o_freeze,    fr);
        check("mem_err",   bus.o_mem_err,   er);
        check("stall_fd",  bus.o_stall_fd,  sfd);
        check("flush_d",   bus.o_flush_d,   fd);
        check("flush_e",   bus.o_flush_e,   fe);
        check("state",     bus.o_state,     st);
        check("stall_cnt", bus.o_stall_cnt, m_cnt);

        if (i_rst) model_reset();
        else if (sfd || fr) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;

        @(posedge i_clk);
        #1;
    endtask

    task automatic reset_cycle();
        in_t v;
        v = idle();
        v.rst = 1'b1;
        apply(v);
        step_cycle();
    endtask

    vec_t vecs[11];

    initial begin
        in_t v;
        int  step_seen;

        // {rst, ld, rd, rs1, rs2, pcsrc, req, ack, halt, step}, stall_fd, flush_d, flush_e, freeze
        vecs[0]  = '{'{0, 1, 5,  0, 5,  0, 0, 0, 0, 0}, 1, 0, 1, 0};
        vecs[1]  = '{'{0, 1, 0,  0, 0,  0, 0, 0, 0, 0}, 0, 0, 0, 0};
        vecs[2]  = '{'{0, 1, 5,  0, 5,  1, 0, 0, 0, 0}, 0, 1, 1, 0};
        vecs[3]  = '{'{0, 0, 5,  5, 0,  0, 0, 0, 0, 0}, 0, 0, 0, 0};
        vecs[4]  = '{'{0, 1, 7,  7, 3,  0, 0, 0, 0, 0}, 1, 0, 1, 0};
        vecs[5]  = '{'{0, 1, 7,  6, 3,  0, 0, 0, 0, 0}, 0, 0, 0, 0};
        vecs[6]  = '{'{0, 0, 0,  0, 0,  1, 0, 0, 0, 0}, 0, 1, 1, 0};
        vecs[7]  = '{'{0, 1, 9,  9, 0,  0, 1, 0, 0, 0}, 0, 0, 0, 1};
        vecs[8]  = '{'{0, 1, 9,  9, 0,  0, 1, 1, 0, 0}, 1, 0, 1, 0};
        vecs[9]  = '{'{0, 0, 0,  0, 0,  1, 1, 0, 0, 0}, 0, 0, 0, 1};
        vecs[10] = '{'{0, 1, 31, 2, 31, 0, 0, 0, 0, 0}, 1, 0, 1, 0};

        // Power-up reset: DUT state is unknown before the first edge.
        v = idle();
        v.rst = 1'b1;
        apply(v);
        @(posedge i_clk);
        #1;
        model_reset();
        apply(idle());
        #1;
        check("reset_state",   bus.o_state,     0);
        check("reset_cnt",     bus.o_stall_cnt, 0);
        check("reset_mem_err", bus.o_mem_err,   0);
        check("reset_freeze",  bus.o_freeze,    0);

        // Single-cycle decode table, each vector from a fresh RUN state.
        for (int i = 0; i < 11; i++) begin
            apply(vecs[i].in);
            #1;
            check($sformatf("vec%0d_stall_fd", i), bus.o_stall_fd, vecs[i].stall_fd);
            check($sformatf("vec%0d_flush_d",  i), bus.o_flush_d,  vecs[i].flush_d);
            check($sformatf("vec%0d_flush_e",  i), bus.o_flush_e,  vecs[i].flush_e);
            check($sformatf("vec%0d_freeze",   i), bus.o_freeze,   vecs[i].freeze);
            step_cycle();
            reset_cycle();
        end

        // Load-use increments the stall counter once.
        v = idle();
        v.ld = 1; v.rd = 5; v.rs2 = 5;
        apply(v);
        step_cycle();
        apply(idle());
        check("lu_cnt", bus.o_stall_cnt, 1);
        step_cycle();
        reset_cycle();

        // Ack arrives on the 4th cycle of the request.
        v = idle();
        v.req = 1;
        for (int i = 0; i < 4; i++) begin
            v.ack = (i == 3);
            apply(v);
            #1;
            check("mw_freeze", bus.o_freeze, (i < 3));
            check("mw_state",  bus.o_state,  (i == 0) ? 0 : 1);
            step_cycle();
        end
        apply(idle());
        check("mw_done_state", bus.o_state,     0);
        check("mw_done_cnt",   bus.o_stall_cnt, 3);
        step_cycle();
        reset_cycle();

        // No ack: abandoned on the 5th cycle with a single error pulse.
        v = idle();
        v.req = 1;
        for (int i = 0; i < 5; i++) begin
            apply(v);
            #1;
            check("tmo_err",   bus.o_mem_err, (i == 4));
            check("tmo_state", bus.o_state,   (i == 0) ? 0 : 1);
            step_cycle();
        end
        apply(idle());
        check("tmo_back_state", bus.o_state,   0);
        check("tmo_no_err",     bus.o_mem_err, 0);
        step_cycle();
        reset_cycle();

        // Halt, two single steps, release.
        v = idle();
        v.halt = 1;
        apply(v);
        step_cycle();
        check("halt_state", bus.o_state, 2);
        step_seen = 0;
        for (int j = 0; j < 6; j++) begin
            v.step = (j == 0 || j == 3);
            apply(v);
            #1;
            if (bus.o_state == 2'b11) begin
                step_seen++;
                check("step_freeze", bus.o_freeze, 0);
            end
            step_cycle();
        end
        check("step_count", step_seen, 2);
        check("halt_again", bus.o_state, 2);
        v = idle();
        v.step = 1;     // step with halt released must not enter STEP
        apply(v);
        step_cycle();
        check("release_state", bus.o_state, 0);
        reset_cycle();

        // Reset during the second MEMWAIT cycle.
        v = idle();
        v.req = 1;
        for (int i = 0; i < 3; i++) begin
            v.rst = (i == 2);
            apply(v);
            #1;
            if (i == 2) check("rst_mw_err", bus.o_mem_err, 0);
            step_cycle();
        end
        apply(idle());
        check("rst_mw_state",   bus.o_state,     0);
        check("rst_mw_cnt",     bus.o_stall_cnt, 0);
        check("rst_mw_err_after", bus.o_mem_err, 0);
        step_cycle();

        // Randomized run against the model.
        v = idle();
        for (int n = 0; n < 3000; n++) begin
            v.rst   = ($urandom_range(0, 99) < 2);
            v.ld    = $urandom_range(0, 1);
            v.rd    = 5'($urandom_range(0, 3));
            v.rs1   = 5'($urandom_range(0, 3));
            v.rs2   = 5'($urandom_range(0, 3));
            v.pcsrc = ($urandom_range(0, 4) == 0);
            v.req   = ($urandom_range(0, 3) == 0);
            v.ack   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) v.halt = !v.halt;
            v.step  = ($urandom_range(0, 2) == 0);
            apply(v);
            step_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
